// File: rtl/div_clk_tick_gen.sv
// Turns divided-clock levels into single-cycle i_clk-domain ticks, with per-channel terminal counters,
// event strobes and sticky status. Define DIV_TICK_SYNC_EN to add a 2-flop synchronizer on each input.
module div_clk_tick_gen #(
    parameter int N   = 4,
    parameter int TCW = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_div_clk,
    input  logic [N-1:0]     i_enable,
    input  logic [N*TCW-1:0] i_terminal,
    input  logic [N-1:0]     i_status_clr,
    output logic [N-1:0]     o_tick,
    output logic [N-1:0]     o_event,
    output logic [N*TCW-1:0] o_count,
    output logic [N-1:0]     o_status
);

    localparam logic [TCW-1:0] count_one = {{(TCW-1){1'b0}}, 1'b1};

    logic [N-1:0]     s;
    logic [N-1:0]     r_prev;
    logic             r_armed;
    logic             arm_load;
    logic [N-1:0]     rise;
    logic [N-1:0]     fire;
    logic [N-1:0]     ev_next;
    logic [N-1:0]     status_next;
    logic [N*TCW-1:0] count_next;

`ifdef DIV_TICK_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [1:0]   r_fill;

    // Arming waits until both synchronizer stages hold real samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= 2'd0;
        end else begin
            r_sync1 <= i_div_clk;
            r_sync2 <= r_sync1;
            if (r_fill != 2'd2)
                r_fill <= r_fill + 2'd1;
        end
    end

    assign s        = r_sync2;
    assign arm_load = (r_fill == 2'd2);
`else
    assign s        = i_div_clk;
    assign arm_load = 1'b1;
`endif

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rise        = {N{r_armed}} & s & ~r_prev;
        fire        = rise & i_enable;
        ev_next     = '0;
        count_next  = o_count;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                // >= lets a lowered terminal wrap on the very next tick.
                if (o_count[i*TCW +: TCW] >= i_terminal[i*TCW +: TCW]) begin
                    count_next[i*TCW +: TCW] = '0;
                    ev_next[i]               = 1'b1;
                end else begin
                    count_next[i*TCW +: TCW] = o_count[i*TCW +: TCW] + count_one;
                end
            end
        end
        // Set wins over clear for the whole event window, including the visible strobe cycle.
        status_next = ev_next | o_event | (o_status & ~i_status_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev   <= '0;
            r_armed  <= 1'b0;
            o_tick   <= '0;
            o_event  <= '0;
            o_count  <= '0;
            o_status <= '0;
        end else begin
            r_prev   <= s;
            r_armed  <= r_armed | arm_load;
            o_tick   <= fire;
            o_event  <= ev_next;
            o_count  <= count_next;
            o_status <= status_next;
        end
    end

endmodule

// File: tb/tb_div_clk_tick_gen.sv
// Randomised scoreboard bench for div_clk_tick_gen: a spec-level model pushes expected outputs per edge,
// a monitor pops and compares them on the falling edge.
module tb_div_clk_tick_gen;

    localparam int N   = 4;
    localparam int TCW = 8;
`ifdef DIV_TICK_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int ARM_EDGES = SYNC ? 3 : 1;

    typedef struct {
        logic [N-1:0]     tick;
        logic [N-1:0]     event_s;
        logic [N*TCW-1:0] count;
        logic [N-1:0]     status;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N-1:0]     i_div_clk;
    logic [N-1:0]     i_enable;
    logic [N*TCW-1:0] i_terminal;
    logic [N-1:0]     i_status_clr;
    logic [N-1:0]     o_tick;
    logic [N-1:0]     o_event;
    logic [N*TCW-1:0] o_count;
    logic [N-1:0]     o_status;

    div_clk_tick_gen #(.N(N), .TCW(TCW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_div_clk   (i_div_clk),
        .i_enable    (i_enable),
        .i_terminal  (i_terminal),
        .i_status_clr(i_status_clr),
        .o_tick      (o_tick),
        .o_event     (o_event),
        .o_count     (o_count),
        .o_status    (o_status)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    // Reference model state: input history, previous sampled level, tick counts.
    logic [N-1:0] m_hist0, m_hist1, m_hist2;
    logic [N-1:0] m_prev, m_event, m_status;
    int           m_count[N];
    int           m_edges;

    logic [N-1:0]     cur_div, cur_en, cur_clr;
    logic [N*TCW-1:0] cur_term;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist0 = '0; m_hist1 = '0; m_hist2 = '0;
        m_prev = '0; m_event = '0; m_status = '0;
        m_edges = 0;
        for (int i = 0; i < N; i++) m_count[i] = 0;
    endtask

    // One clock edge of the specified behaviour, given the inputs applied before it.
    task automatic model_edge(input logic [N-1:0] div, input logic [N-1:0] en,
                              input logic [N-1:0] clr, input logic [N*TCW-1:0] term);
        logic [N-1:0] smp, tick, ev, st;
        exp_t e;
        int t;
        m_hist2 = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = div;
        smp = SYNC ? m_hist2 : m_hist0;
        tick = '0;
        ev   = '0;
        for (int i = 0; i < N; i++) begin
            if (m_edges >= ARM_EDGES && smp[i] && !m_prev[i] && en[i]) begin
                tick[i] = 1'b1;
                t = int'(term[i*TCW +: TCW]);
                if (m_count[i] >= t) begin
                    m_count[i] = 0;
                    ev[i] = 1'b1;
                end else begin
                    m_count[i] = m_count[i] + 1;
                end
            end
            st[i] = ev[i] || m_event[i] || (m_status[i] && !clr[i]);
        end
        m_prev   = smp;
        m_event  = ev;
        m_status = st;
        m_edges++;
        e.tick    = tick;
        e.event_s = ev;
        e.status  = st;
        for (int i = 0; i < N; i++) e.count[i*TCW +: TCW] = m_count[i][TCW-1:0];
        sb_q.push_back(e);
    endtask

    task automatic step();
        i_div_clk    = cur_div;
        i_enable     = cur_en;
        i_status_clr = cur_clr;
        i_terminal   = cur_term;
        @(posedge i_clk);
        model_edge(cur_div, cur_en, cur_clr, cur_term);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Monitor: compares every registered output against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("tick",   64'(o_tick),   64'(e.tick));
                check("event",  64'(o_event),  64'(e.event_s));
                check("count",  64'(o_count),  64'(e.count));
                check("status", 64'(o_status), 64'(e.status));
            end
        end
    end

    initial begin
        int hold[N];
        int guard;

        cur_div  = '1;
        cur_en   = '1;
        cur_clr  = '0;
        cur_term = {N{8'd3}};
        i_rst        = 1'b1;
        i_div_clk    = cur_div;
        i_enable     = cur_en;
        i_status_clr = cur_clr;
        i_terminal   = cur_term;
        model_reset();
        #7;
        check("reset_tick",   64'(o_tick),   64'd0);
        check("reset_event",  64'(o_event),  64'd0);
        check("reset_count",  64'(o_count),  64'd0);
        check("reset_status", 64'(o_status), 64'd0);
        #1 i_rst = 1'b0;

        // Inputs already high at reset release must not tick.
        steps(6);

        // Channel 0 square wave, period 16, terminal 3; other channels idle low.
        cur_div = '0;
        steps(4);
        for (int p = 0; p < 5; p++) begin
            cur_div[0] = 1'b0; steps(8);
            cur_div[0] = 1'b1; steps(8);
        end
        cur_div[0] = 1'b0; steps(4);

        // Channel 3: count to 5 with terminal 7, then lower terminal to 2.
        cur_term[3*TCW +: TCW] = 8'd7;
        guard = 0;
        while (m_count[3] != 5 && guard < 20) begin
            cur_div[3] = 1'b1; steps(2);
            cur_div[3] = 1'b0; steps(2);
            guard++;
        end
        check("lower_setup_reached", 64'(guard < 20), 64'd1);
        cur_term[3*TCW +: TCW] = 8'd2;
        cur_div[3] = 1'b1; steps(2);
        cur_div[3] = 1'b0; steps(2);

        // Channel 1 disabled across 3 edges, then re-enabled while the input is high.
        cur_en[1] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cur_div[1] = 1'b1; steps(4);
            cur_div[1] = 1'b0; steps(4);
        end
        cur_div[1] = 1'b1; steps(3);
        cur_en[1] = 1'b1;  steps(4);
        cur_div[1] = 1'b0; steps(3);

        // Channel 2, terminal 0: clear lands on the o_event cycle, then a later clear takes effect.
        cur_term[2*TCW +: TCW] = 8'd0;
        cur_div[2] = 1'b1;
        steps(SYNC ? 3 : 1);
        cur_clr[2] = 1'b1; step();
        cur_clr[2] = 1'b0; steps(3);
        cur_clr[2] = 1'b1; step();
        cur_clr[2] = 1'b0; steps(2);
        cur_div[2] = 1'b0; steps(3);

        // Randomised traffic within the 2-cycle toggle contract.
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(2, 9);
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    cur_div[i] = ~cur_div[i];
                    hold[i] = $urandom_range(2, 9);
                end
                hold[i]--;
                if ($urandom_range(0, 63) == 0)
                    cur_term[i*TCW +: TCW] = TCW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 15) == 0) cur_en = N'($urandom);
            cur_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            step();
        end
        cur_clr = '0;
        steps(4);

        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_clk_tick_gen.md
Name: div_clk_tick_gen

Overview:
- Sits directly downstream of the team's counter-based clock divider and consumes its N divided-clock outputs.
- Converts each divided clock into a single-cycle tick strobe in the i_clk domain, because divided clocks must never be used as real clocks.
- Each channel also has a programmable tick counter that produces a periodic event pulse and a sticky status bit.
- Consumers are timers, LED blinkers and other slow periodic logic that run on i_clk with enables.

Parameters:
- N, 4, number of divided-clock channels.
- TCW, 8, width of each per-channel tick counter and terminal value.

Ports:
- i_clk  input  1  system clock; the divider runs on the same clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_div_clk  input  N  divided-clock levels from the divider.
- i_enable  input  N  per-channel enable; level-sensitive.
- i_terminal  input  N*TCW  per-channel terminal count; channel i uses bits [i*TCW +: TCW].
- i_status_clr  input  N  per-channel sticky-status clear; single-cycle pulse.
- o_tick  output  N  one-cycle strobe per rising edge of i_div_clk[i]; registered.
- o_event  output  N  one-cycle strobe when the channel counter reaches its terminal; registered.
- o_count  output  N*TCW  current per-channel tick count.
- o_status  output  N  sticky flag, set by o_event.

Behaviour:
- Reset (i_rst high, asynchronous) clears everything: o_tick=0, o_event=0, o_count=0, o_status=0, r_prev=0, r_armed=0.
- Arming:
  - The first i_clk edge after reset deassertion loads r_prev from the sampled input and sets r_armed=1.
  - No tick can occur on that edge, so an input already high at reset release does not produce a spurious tick.
- Edge detect, per channel i:
  - rise = r_armed & s[i] & ~r_prev[i], where s is the sampled input (see Optional Feature).
  - r_prev[i] <= s[i] every cycle, regardless of i_enable.
  - o_tick[i] <= rise & i_enable[i]. Latency is 1 cycle from the rising sample to o_tick.
- Counter, per channel, evaluated when rise & i_enable:
  - If count >= terminal: count <= 0 and o_event <= 1.
  - Else: count <= count + 1 and o_event <= 0.
  - With terminal T, o_event fires on every (T+1)-th tick, in the same cycle as that o_tick. T=0 gives an event on every tick.
  - count >= terminal, rather than ==, covers the terminal being lowered mid-count: the next tick wraps the counter to 0 and fires the event. No overflow is possible.
- Enable:
  - i_enable[i]=0 suppresses tick and event and holds count.
  - Edges that occur while disabled are lost, not queued.
  - Re-enabling does not fire a tick unless a fresh rising edge is sampled.
- Status:
  - o_status[i] is set on an o_event[i] cycle (the same edge that registers o_event) and cleared by i_status_clr[i].
  - If set and clear happen in the same cycle, set wins.
- o_count is the registered counter value, updated on the same edge as o_tick.
- Channels are fully independent, and all outputs are registered.
- An input that toggles faster than every 2 i_clk cycles is out of contract; every sampled 0→1 transition yields a tick.

Optional Feature:
- Macro: DIV_TICK_SYNC_EN.
- Defined: each i_div_clk bit passes through a 2-flop synchronizer (reset to 0) before edge detect, which adds 2 cycles of latency.
  - Total latency is 3 cycles from the input rise to o_tick.
  - r_armed sets only after the synchronizer has been loaded, i.e. on the 3rd edge after reset release.
  - Use this when the divider sits in another clock domain.
- Undefined: the input is used directly as s, with 1-cycle latency and arming on the 1st edge.

Test Plan (feature undefined unless noted):
- Reset release: hold i_div_clk=4'b1111 and i_enable=4'hF across reset release -> o_tick stays 0 for at least 4 cycles; o_count=0.
- Basic tick: drive a 0→1 transition on channel 0 (period 16 i_clk, enable=1) -> o_tick[0] high for exactly 1 cycle, 1 cycle after the rising sample, once per 16 cycles.
- Terminal: terminal[0]=3 -> o_count[0] steps 1,2,3,0; o_event[0] on every 4th tick; o_status[0]=1 after the first event.
- Terminal lowered: count at 5, terminal set to 2 -> next tick gives o_count=0 and o_event=1.
- Enable and status: i_enable[1]=0 across 3 input edges -> no ticks, count held. Then i_status_clr[2] asserted in the same cycle as o_event[2] -> o_status[2] remains 1.
- Sync latency (DIV_TICK_SYNC_EN defined): input rise -> o_tick 3 cycles later; no tick if the input was high at reset release.
